pwm_modulator: RTL and testbench
================================

# pwm_modulator

Converts a stream of unsigned 8-bit audio samples into a 1-bit pulse-width-modulated output for an external RC low-pass filter. It is the stage directly downstream of `pwmaudio`: it consumes `pwmaudio`'s registered sample output through a valid/ready handshake and drives the FPGA pin. The block double-buffers samples (active plus pending), so a new sample can be accepted while the current PWM period is still running.

## Interface
- `DATA_W`, default 8: sample width; the PWM period is 2^DATA_W ticks.
- `PRESCALE`, default 1: clocks per PWM tick, valid range 1..65535.
- `i_clk`  input  1: single clock.
- `i_reset`  input  1: reset, synchronous, active-high.
- `i_data`  input  DATA_W: unsigned sample (duty = value / 2^DATA_W).
- `i_valid`  input  1: `i_data` is valid.
- `o_ready`  output  1: block accepts `i_data` this cycle.
- `o_pwm`  output  1: registered PWM output.
- `o_underrun`  output  1: one-cycle pulse when a period ends with no pending sample.

## Operation
- Accept occurs on any cycle where `i_valid && o_ready` are both high.
- FSM has two states, IDLE and RUN. Reset enters IDLE.
- **IDLE**
  - prescaler and `pwm_cnt` held at 0; `o_pwm` = 0; `o_ready` = 1.
  - First accept: `active` <= `i_data`, prescaler <= 0, `pwm_cnt` <= 0, state <= RUN. The sample bypasses the pending slot.
- **RUN**
  - Prescaler counts 0..PRESCALE-1. `tick` = (prescaler == PRESCALE-1).
  - On `tick`, `pwm_cnt` increments and wraps from 2^DATA_W-1 to 0.
  - `boundary` = `tick && pwm_cnt == 2^DATA_W-1`.
  - `o_ready` = `!pending_valid || boundary`. This is combinational from registers, not from `i_valid`.
  - Accept with no boundary: `pending` <= `i_data`, `pending_valid` <= 1.
  - Boundary with `pending_valid` set: `active` <= `pending`. If the same cycle also accepts, `pending` <= `i_data` and `pending_valid` stays 1; otherwise `pending_valid` <= 0.
  - Boundary with `pending_valid` clear: `active` holds its value and `o_underrun` pulses on the next cycle. A sample accepted in this same cycle goes to `pending`, not to `active`.
- RUN never returns to IDLE except through reset.
- Compare rule: `o_pwm` <= (`pwm_cnt` < `active`), unsigned and DATA_W bits wide.
  - 0x00 gives constant low.
  - 0xFF gives 255 of every 256 ticks high. 100% duty is unreachable by design.
- Reset mid-operation: the pending sample is dropped, `active` <= 0, state returns to IDLE.

## Timing
- Reset values: `o_pwm` = 0, `o_underrun` = 0, `o_ready` = 0 while `i_reset` is high, `active` = 0, `pending_valid` = 0, state IDLE.
- First-sample latency: accept in cycle T. RUN starts at T+1 with `pwm_cnt` = 0. `o_pwm` reflects the first comparison at T+2.
- Period length is `PRESCALE` × 2^DATA_W clocks exactly, with no gap between periods.
- A new `active` value affects `o_pwm` starting 1 cycle after the boundary edge.
- `o_underrun` asserts 1 cycle after the boundary cycle and lasts exactly 1 cycle.

## Configuration
- Macro: `PWM_MODULATOR_UNDERRUN_CNT_EN`.
- **Defined:** adds output `o_underrun_cnt` (16 bits).
  - Increments on every `o_underrun` pulse and saturates at 0xFFFF.
  - Reset value 0. Cleared only by reset.
- **Undefined:** the port and the counter logic are absent. All other behaviour is identical.

## Structure
- Package `pwm_modulator_pkg` holds:
  - FSM state typedef (IDLE, RUN);
  - `DEFAULT_DATA_W` = 8;
  - `DEFAULT_PRESCALE` = 1;
  - `UNDERRUN_CNT_W` = 16.
- Sub-module `pwm_tick_gen` (parameter `PRESCALE`; inputs clock, reset, enable; output `o_tick`) implements the prescaler. The top level instantiates it with enable = (state == RUN).

## Test plan
- **Reset/idle:** hold `i_reset` for 5 cycles, then release with `i_valid` = 0 → `o_pwm` = 0 and `o_underrun` = 0 throughout; `o_ready` = 0 during reset and 1 afterwards.
- **Single sample:** PRESCALE = 1; accept 0x40 once → `o_pwm` high for 64 clocks then low for 192, starting at T+2. `o_underrun` pulses at T+1+256. The following period repeats duty 0x40.
- **Extremes:** stream 0x00 then 0xFF back to back → the first period has 0 high clocks; the second has 255 high clocks and 1 low clock. No underrun pulse.
- **Backpressure:** present 3 samples on consecutive cycles → the first is accepted (IDLE bypass), the second is accepted into pending, and `o_ready` stays low until the boundary cycle, 256 clocks into RUN. The third is accepted on exactly that cycle.
- **Prescale:** PRESCALE = 4, sample 0x80 → period of 1024 clocks with 512 high.
- **Reset mid-period:** at clock 100 of a 0xC0 period with a pending sample, assert `i_reset` → next cycle `o_pwm` = 0 and state IDLE. The pending sample never appears; the next accepted sample starts a fresh period. With `PWM_MODULATOR_UNDERRUN_CNT_EN` defined, `o_underrun_cnt` reads 0.

Source files
------------

// File: rtl/pwm_modulator_pkg.sv
// Shared types and defaults for the PWM audio modulator.
package pwm_modulator_pkg;
  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  localparam int DEFAULT_DATA_W   = 8;
  localparam int DEFAULT_PRESCALE = 1;
  localparam int UNDERRUN_CNT_W   = 16;
endpackage

// File: rtl/pwm_tick_gen.sv
// PWM prescaler: o_tick is high on the last clock of every PRESCALE-clock window while enabled.
module pwm_tick_gen #(
  parameter int PRESCALE = 1
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_en,
  output logic o_tick
);
  localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(PRESCALE - 1);

  logic [CNT_W-1:0] cnt;

  assign o_tick = i_en && (cnt == LAST);

  always_ff @(posedge i_clk) begin
    if (i_reset || !i_en || o_tick) cnt <= '0;
    else                            cnt <= cnt + CNT_W'(1);
  end
endmodule

// File: rtl/pwm_modulator.sv
// Double-buffered sample-to-PWM converter. Define PWM_MODULATOR_UNDERRUN_CNT_EN
// to add a saturating 16-bit underrun counter output (o_underrun_cnt).
module pwm_modulator
  import pwm_modulator_pkg::*;
#(
  parameter int DATA_W   = DEFAULT_DATA_W,
  parameter int PRESCALE = DEFAULT_PRESCALE
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_valid,
  output logic              o_ready,
  output logic              o_pwm,
  output logic              o_underrun
`ifdef PWM_MODULATOR_UNDERRUN_CNT_EN
  ,
  output logic [UNDERRUN_CNT_W-1:0] o_underrun_cnt
`endif
);
  localparam logic [DATA_W-1:0] CNT_MAX = '1;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] active, pending, pwm_cnt;
  logic              pending_valid;
  logic              run, tick, boundary, accept;

  assign run      = (state == RUN);
  assign boundary = tick && (pwm_cnt == CNT_MAX);
  // Ready is registered-state only; a boundary frees the pending slot in the same cycle.
  assign o_ready  = !i_reset && (!run || !pending_valid || boundary);
  assign accept   = i_valid && o_ready;

  pwm_tick_gen #(.PRESCALE(PRESCALE)) u_tick (
    .i_clk  (i_clk),
    .i_reset(i_reset),
    .i_en   (run),
    .o_tick (tick)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = RUN;
      RUN:     state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      active        <= '0;
      pending       <= '0;
      pending_valid <= 1'b0;
      pwm_cnt       <= '0;
      o_pwm         <= 1'b0;
      o_underrun    <= 1'b0;
    end else begin
      o_underrun <= 1'b0;
      if (!run) begin
        o_pwm   <= 1'b0;
        pwm_cnt <= '0;
        if (accept) active <= i_data;
      end else begin
        o_pwm <= (pwm_cnt < active);
        if (tick) pwm_cnt <= pwm_cnt + DATA_W'(1);
        if (boundary) begin
          if (pending_valid) active     <= pending;
          else               o_underrun <= 1'b1;
        end
        // An accept always lands in pending, even on an underrun boundary.
        if (accept) begin
          pending       <= i_data;
          pending_valid <= 1'b1;
        end else if (boundary && pending_valid) begin
          pending_valid <= 1'b0;
        end
      end
    end
  end

`ifdef PWM_MODULATOR_UNDERRUN_CNT_EN
  always_ff @(posedge i_clk) begin
    if (i_reset)                                 o_underrun_cnt <= '0;
    else if (o_underrun && (o_underrun_cnt != '1)) o_underrun_cnt <= o_underrun_cnt + UNDERRUN_CNT_W'(1);
  end
`endif
endmodule

// File: tb/tb_pwm_modulator.sv
// Directed self-checking bench for pwm_modulator (PRESCALE=1 and PRESCALE=4 instances).
module tb_pwm_modulator;
  logic       clk = 1'b0;
  logic       i_reset = 1'b1;
  logic [7:0] i_data = '0, i_data4 = '0;
  logic       i_valid = 1'b0, i_valid4 = 1'b0;
  logic       o_ready, o_pwm, o_underrun;
  logic       o_ready4, o_pwm4, o_underrun4;
`ifdef PWM_MODULATOR_UNDERRUN_CNT_EN
  logic [15:0] o_underrun_cnt, o_underrun_cnt4;
`endif

  int n_checks = 0;
  int n_err    = 0;

  logic pwm_log [0:1100];
  logic und_log [0:1100];
  logic rdy_log [0:1100];

  always #5 clk = ~clk;

  pwm_modulator #(.DATA_W(8), .PRESCALE(1)) dut (
    .i_clk(clk), .i_reset(i_reset), .i_data(i_data), .i_valid(i_valid),
    .o_ready(o_ready), .o_pwm(o_pwm), .o_underrun(o_underrun)
`ifdef PWM_MODULATOR_UNDERRUN_CNT_EN
    , .o_underrun_cnt(o_underrun_cnt)
`endif
  );

  pwm_modulator #(.DATA_W(8), .PRESCALE(4)) dut4 (
    .i_clk(clk), .i_reset(i_reset), .i_data(i_data4), .i_valid(i_valid4),
    .o_ready(o_ready4), .o_pwm(o_pwm4), .o_underrun(o_underrun4)
`ifdef PWM_MODULATOR_UNDERRUN_CNT_EN
    , .o_underrun_cnt(o_underrun_cnt4)
`endif
  );

  // Cycle k of a capture: inputs were set at posedge+1, outputs sampled at posedge+2.
  task automatic sample_adv(input int k);
    #1;
    pwm_log[k] = o_pwm;
    und_log[k] = o_underrun;
    rdy_log[k] = o_ready;
    @(posedge clk); #1;
  endtask

  function automatic int highs(input int a, input int b);
    int n = 0;
    for (int i = a; i <= b; i++) if (pwm_log[i] === 1'b1) n++;
    return n;
  endfunction

  function automatic int unders(input int a, input int b);
    int n = 0;
    for (int i = a; i <= b; i++) if (und_log[i] === 1'b1) n++;
    return n;
  endfunction

  task automatic do_reset();
    i_reset = 1'b1; i_valid = 1'b0; i_valid4 = 1'b0;
    @(posedge clk); #1;
    i_reset = 1'b0;
  endtask

  task automatic test_reset();
    int bad = 0;
    i_reset = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #2;
      if (o_pwm !== 1'b0 || o_underrun !== 1'b0 || o_ready !== 1'b0) bad++;
    end
    n_checks++;
    if (bad !== 0) begin
      n_err++; $display("FAIL reset_hold: %0d bad cycles, required 0 (pwm=%b und=%b rdy=%b)", bad, o_pwm, o_underrun, o_ready);
    end
    @(posedge clk); #1;
    i_reset = 1'b0;
    bad = 0;
    for (int c = 0; c < 5; c++) begin
      #1;
      if (o_pwm !== 1'b0 || o_underrun !== 1'b0 || o_ready !== 1'b1) bad++;
      @(posedge clk); #1;
    end
    n_checks++;
    if (bad !== 0) begin
      n_err++; $display("FAIL idle_after_reset: %0d bad cycles, required 0", bad);
    end
  endtask

  task automatic test_single();
    do_reset();
    i_valid = 1'b1; i_data = 8'h40;
    for (int k = 0; k < 600; k++) begin
      if (k == 1) i_valid = 1'b0;
      sample_adv(k);
    end
    n_checks++; if (pwm_log[1] !== 1'b0) begin n_err++; $display("FAIL single_T1: pwm=%b required 0", pwm_log[1]); end
    n_checks++; if (pwm_log[2] !== 1'b1) begin n_err++; $display("FAIL single_T2: pwm=%b required 1", pwm_log[2]); end
    n_checks++; if (pwm_log[65] !== 1'b1 || pwm_log[66] !== 1'b0) begin
      n_err++; $display("FAIL single_edge: pwm65=%b pwm66=%b required 1,0", pwm_log[65], pwm_log[66]); end
    n_checks++; if (highs(2, 257) !== 64) begin n_err++; $display("FAIL single_duty1: highs=%0d required 64", highs(2, 257)); end
    n_checks++; if (und_log[256] !== 1'b0 || und_log[257] !== 1'b1 || und_log[258] !== 1'b0) begin
      n_err++; $display("FAIL single_underrun: und256..258=%b%b%b required 010", und_log[256], und_log[257], und_log[258]); end
    n_checks++; if (highs(258, 513) !== 64) begin n_err++; $display("FAIL single_duty2: highs=%0d required 64", highs(258, 513)); end
`ifdef PWM_MODULATOR_UNDERRUN_CNT_EN
    n_checks++; if (o_underrun_cnt !== 16'd2) begin n_err++; $display("FAIL single_ucnt: cnt=%0d required 2", o_underrun_cnt); end
`endif
  endtask

  task automatic test_extremes();
    do_reset();
    i_valid = 1'b1; i_data = 8'h00;
    for (int k = 0; k < 520; k++) begin
      if (k == 1) i_data = 8'hFF;
      if (k == 2) i_valid = 1'b0;
      sample_adv(k);
    end
    n_checks++; if (highs(2, 257) !== 0) begin n_err++; $display("FAIL ext_zero: highs=%0d required 0", highs(2, 257)); end
    n_checks++; if (highs(258, 513) !== 255) begin n_err++; $display("FAIL ext_full: highs=%0d required 255", highs(258, 513)); end
    n_checks++; if (pwm_log[513] !== 1'b0) begin n_err++; $display("FAIL ext_last_low: pwm=%b required 0", pwm_log[513]); end
    n_checks++; if (unders(1, 512) !== 0) begin n_err++; $display("FAIL ext_no_underrun: pulses=%0d required 0", unders(1, 512)); end
  endtask

  task automatic test_back_to_back();
    int acc_c = -1;
    int low_bad = 0;
    do_reset();
    i_valid = 1'b1; i_data = 8'h10;
    for (int k = 0; k < 771; k++) begin
      if (k == 1) i_data = 8'h20;
      if (k == 2) i_data = 8'h30;
      sample_adv(k);
      if (k >= 2 && acc_c < 0 && rdy_log[k] === 1'b1) begin
        acc_c = k; i_valid = 1'b0;
      end
    end
    for (int k = 2; k < 256; k++) if (rdy_log[k] !== 1'b0) low_bad++;
    n_checks++; if (rdy_log[0] !== 1'b1 || rdy_log[1] !== 1'b1) begin
      n_err++; $display("FAIL bp_first_two: rdy0=%b rdy1=%b required 1,1", rdy_log[0], rdy_log[1]); end
    n_checks++; if (low_bad !== 0) begin n_err++; $display("FAIL bp_ready_low: %0d high cycles, required 0", low_bad); end
    n_checks++; if (acc_c !== 256) begin n_err++; $display("FAIL bp_third_accept: cycle=%0d required 256", acc_c); end
    n_checks++; if (highs(2, 257) !== 16) begin n_err++; $display("FAIL bp_duty_a: highs=%0d required 16", highs(2, 257)); end
    n_checks++; if (highs(258, 513) !== 32) begin n_err++; $display("FAIL bp_duty_b: highs=%0d required 32", highs(258, 513)); end
    n_checks++; if (highs(514, 769) !== 48) begin n_err++; $display("FAIL bp_duty_c: highs=%0d required 48", highs(514, 769)); end
    n_checks++; if (unders(1, 768) !== 0 || und_log[769] !== 1'b1) begin
      n_err++; $display("FAIL bp_underrun: early=%0d last=%b required 0,1", unders(1, 768), und_log[769]); end
  endtask

  task automatic test_prescale();
    do_reset();
    i_valid4 = 1'b1; i_data4 = 8'h80;
    for (int k = 0; k < 1030; k++) begin
      if (k == 1) i_valid4 = 1'b0;
      #1;
      pwm_log[k] = o_pwm4;
      und_log[k] = o_underrun4;
      @(posedge clk); #1;
    end
    n_checks++; if (highs(2, 1025) !== 512) begin n_err++; $display("FAIL ps_duty: highs=%0d required 512", highs(2, 1025)); end
    n_checks++; if (pwm_log[513] !== 1'b1 || pwm_log[514] !== 1'b0) begin
      n_err++; $display("FAIL ps_edge: pwm513=%b pwm514=%b required 1,0", pwm_log[513], pwm_log[514]); end
    n_checks++; if (unders(1, 1024) !== 0 || und_log[1025] !== 1'b1) begin
      n_err++; $display("FAIL ps_period: early=%0d at1025=%b required 0,1", unders(1, 1024), und_log[1025]); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    i_valid = 1'b1; i_data = 8'hC0;
    for (int k = 0; k < 102; k++) begin
      if (k == 1) i_data = 8'h11;
      if (k == 2) i_valid = 1'b0;
      if (k == 100) i_reset = 1'b1;
      if (k == 101) i_reset = 1'b0;
      sample_adv(k);
    end
    n_checks++; if (pwm_log[100] !== 1'b1 || rdy_log[100] !== 1'b0) begin
      n_err++; $display("FAIL mid_at_reset: pwm=%b rdy=%b required 1,0", pwm_log[100], rdy_log[100]); end
    n_checks++; if (pwm_log[101] !== 1'b0 || rdy_log[101] !== 1'b1) begin
      n_err++; $display("FAIL mid_after_reset: pwm=%b rdy=%b required 0,1", pwm_log[101], rdy_log[101]); end
`ifdef PWM_MODULATOR_UNDERRUN_CNT_EN
    n_checks++; if (o_underrun_cnt !== 16'd0) begin n_err++; $display("FAIL mid_ucnt: cnt=%0d required 0", o_underrun_cnt); end
`endif
    i_valid = 1'b1; i_data = 8'h08;
    for (int k = 0; k < 515; k++) begin
      if (k == 1) i_valid = 1'b0;
      sample_adv(k);
    end
    n_checks++; if (pwm_log[2] !== 1'b1 || pwm_log[9] !== 1'b1 || pwm_log[10] !== 1'b0) begin
      n_err++; $display("FAIL mid_fresh: pwm2=%b pwm9=%b pwm10=%b required 1,1,0", pwm_log[2], pwm_log[9], pwm_log[10]); end
    n_checks++; if (highs(2, 257) !== 8 || highs(258, 513) !== 8) begin
      n_err++; $display("FAIL mid_no_stale: highs=%0d,%0d required 8,8", highs(2, 257), highs(258, 513)); end
    n_checks++; if (und_log[257] !== 1'b1) begin n_err++; $display("FAIL mid_underrun: und=%b required 1", und_log[257]); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_extremes();
    test_back_to_back();
    test_prescale();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
